// File: rtl/spi_slave.sv
// SPI responder: oversampled sclk/cs/mosi, LSB-first 8-bit words, buffered transmit byte.
// Optional tri-state enable output miso_oe when SPI_SLAVE_MISO_OE_EN is defined.
module spi_slave #(
  parameter bit          CPOL        = 1'b0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sclk,
  input  logic       cs,
  input  logic       mosi,
  output logic       miso,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic       busy,
  output logic       frame_abort
`ifdef SPI_SLAVE_MISO_OE_EN
  ,
  output logic       miso_oe
`endif
);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q, flush_q;
  logic                   sclk_s, cs_s, mosi_s, flushed;

  assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s    = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
  assign flushed = flush_q[SYNC_STAGES-1];

  // flush_q marks when the chains hold real samples rather than reset presets.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_q <= {SYNC_STAGES{CPOL}};
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      flush_q     <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      flush_q     <= {flush_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  state_e     state_q, state_d;
  logic       sclk_prev_q, sclk_prev_d;
  logic       cs_prev_q, cs_prev_d;
  logic       armed_q, armed_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] tx_buf_q, tx_buf_d;
  logic       tx_ready_q, tx_ready_d;
  logic       word_bnd_q, word_bnd_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       miso_q, miso_d;
  logic       busy_q, busy_d;
  logic       frame_abort_q, frame_abort_d;

  logic lead, trail, cs_fall, cs_rise, consume;

  assign lead    = CPOL ? (sclk_prev_q & ~sclk_s) : (~sclk_prev_q & sclk_s);
  assign trail   = CPOL ? (~sclk_prev_q & sclk_s) : (sclk_prev_q & ~sclk_s);
  assign cs_fall = cs_prev_q & ~cs_s;
  assign cs_rise = ~cs_prev_q & cs_s;

  always_comb begin
    state_d       = state_q;
    sclk_prev_d   = sclk_s;
    cs_prev_d     = cs_s;
    // A frame already running at reset release is ignored until cs is seen high.
    armed_d       = armed_q | (flushed & cs_s);
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    tx_buf_d      = tx_buf_q;
    tx_ready_d    = tx_ready_q;
    word_bnd_d    = word_bnd_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    miso_d        = miso_q;
    busy_d        = busy_q;
    frame_abort_d = 1'b0;
    consume       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cs_fall && armed_q) begin
          state_d    = StActive;
          bit_cnt_d  = 3'd0;
          busy_d     = 1'b1;
          word_bnd_d = 1'b0;
          rx_shift_d = 8'h00;
          consume    = 1'b1;
        end
      end
      StActive: begin
        if (cs_rise) begin
          state_d       = StIdle;
          busy_d        = 1'b0;
          miso_d        = 1'b0;
          frame_abort_d = (bit_cnt_q != 3'd0);
          rx_shift_d    = 8'h00;
          bit_cnt_d     = 3'd0;
          word_bnd_d    = 1'b0;
        end else if (lead) begin
          rx_shift_d = {mosi_s, rx_shift_q[7:1]};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_data_d  = rx_shift_d;
            rx_valid_d = 1'b1;
            word_bnd_d = 1'b1;
          end
        end else if (trail) begin
          if (word_bnd_q) begin
            consume    = 1'b1;
            word_bnd_d = 1'b0;
          end else begin
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            miso_d     = tx_shift_d[0];
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (consume) begin
      tx_shift_d = tx_ready_q ? 8'h00 : tx_buf_q;
      miso_d     = tx_shift_d[0];
      tx_ready_d = 1'b1;
    end
    // A load coincident with a consume is accepted; the consume took the old byte.
    if (tx_load && (tx_ready_q || consume)) begin
      tx_buf_d   = tx_data;
      tx_ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      sclk_prev_q   <= CPOL;
      cs_prev_q     <= 1'b1;
      armed_q       <= 1'b0;
      bit_cnt_q     <= 3'd0;
      rx_shift_q    <= 8'h00;
      tx_shift_q    <= 8'h00;
      tx_buf_q      <= 8'h00;
      tx_ready_q    <= 1'b1;
      word_bnd_q    <= 1'b0;
      rx_data_q     <= 8'h00;
      rx_valid_q    <= 1'b0;
      miso_q        <= 1'b0;
      busy_q        <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sclk_prev_q   <= sclk_prev_d;
      cs_prev_q     <= cs_prev_d;
      armed_q       <= armed_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      tx_buf_q      <= tx_buf_d;
      tx_ready_q    <= tx_ready_d;
      word_bnd_q    <= word_bnd_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      miso_q        <= miso_d;
      busy_q        <= busy_d;
      frame_abort_q <= frame_abort_d;
    end
  end

  assign miso        = miso_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_ready    = tx_ready_q;
  assign busy        = busy_q;
  assign frame_abort = frame_abort_q;

`ifdef SPI_SLAVE_MISO_OE_EN
  assign miso_oe = (state_q == StActive);
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: CPOL=0 and CPOL=1 instances driven in lockstep (sclk1 = ~sclk0),
// received bytes checked through a scoreboard queue per instance.
module tb_spi_slave;

  localparam int HALF = 10;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sclk0;
  logic       sclk1;
  logic       cs;
  logic       mosi;
  logic [7:0] tx_data;
  logic       tx_load;

  logic       miso0, miso1, rx_valid0, rx_valid1, tx_ready0, tx_ready1;
  logic       busy0, busy1, frame_abort0, frame_abort1;
  logic [7:0] rx_data0, rx_data1;
`ifdef SPI_SLAVE_MISO_OE_EN
  logic       miso_oe0, miso_oe1;
`endif

  assign sclk1 = ~sclk0;

  int checks   = 0;
  int failures = 0;
  int abort_cnt0 = 0;
  int abort_cnt1 = 0;
  logic [7:0] exp0_q[$];
  logic [7:0] exp1_q[$];

  always #5 clk = ~clk;

  spi_slave #(.CPOL(1'b0), .SYNC_STAGES(2)) u_dut0 (
    .clk         (clk),
    .reset_n     (reset_n),
    .sclk        (sclk0),
    .cs          (cs),
    .mosi        (mosi),
    .miso        (miso0),
    .rx_data     (rx_data0),
    .rx_valid    (rx_valid0),
    .tx_data     (tx_data),
    .tx_load     (tx_load),
    .tx_ready    (tx_ready0),
    .busy        (busy0),
    .frame_abort (frame_abort0)
`ifdef SPI_SLAVE_MISO_OE_EN
    ,
    .miso_oe     (miso_oe0)
`endif
  );

  spi_slave #(.CPOL(1'b1), .SYNC_STAGES(2)) u_dut1 (
    .clk         (clk),
    .reset_n     (reset_n),
    .sclk        (sclk1),
    .cs          (cs),
    .mosi        (mosi),
    .miso        (miso1),
    .rx_data     (rx_data1),
    .rx_valid    (rx_valid1),
    .tx_data     (tx_data),
    .tx_load     (tx_load),
    .tx_ready    (tx_ready1),
    .busy        (busy1),
    .frame_abort (frame_abort1)
`ifdef SPI_SLAVE_MISO_OE_EN
    ,
    .miso_oe     (miso_oe1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard side: pop expected byte whenever a DUT strobes rx_valid.
  always @(negedge clk) begin
    if (reset_n) begin
      if (rx_valid0) begin
        if (exp0_q.size() == 0) check("rx0_unexpected", 32'd1, 32'd0);
        else check("rx0_data", {24'd0, rx_data0}, {24'd0, exp0_q.pop_front()});
        if (frame_abort0) check("rx0_abort_excl", 32'd1, 32'd0);
      end
      if (rx_valid1) begin
        if (exp1_q.size() == 0) check("rx1_unexpected", 32'd1, 32'd0);
        else check("rx1_data", {24'd0, rx_data1}, {24'd0, exp1_q.pop_front()});
        if (frame_abort1) check("rx1_abort_excl", 32'd1, 32'd0);
      end
      if (frame_abort0) abort_cnt0++;
      if (frame_abort1) abort_cnt1++;
    end
  end

  task automatic load_tx(input logic [7:0] val);
    tx_data = val;
    tx_load = 1'b1;
    wait_clk(1);
    tx_load = 1'b0;
    wait_clk(1);
  endtask

  task automatic cs_low();
    cs = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic cs_high();
    wait_clk(HALF);
    cs = 1'b1;
    wait_clk(2 * HALF);
  endtask

  // Mode-0 style initiator: mosi set after trailing edge, miso sampled at leading edge.
  task automatic spi_bits(input logic [7:0] mo, input int nbits, input logic [7:0] exp_mi,
                          input bit expect_rx);
    if (expect_rx) begin
      exp0_q.push_back(mo);
      exp1_q.push_back(mo);
    end
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[i];
      wait_clk(HALF);
      check("miso0_bit", {31'd0, miso0}, {31'd0, exp_mi[i]});
      check("miso1_bit", {31'd0, miso1}, {31'd0, exp_mi[i]});
      sclk0 = 1'b1;
      wait_clk(HALF);
      sclk0 = 1'b0;
    end
  endtask

  task automatic check_idle(input string tag, input logic [7:0] exp_rx);
    check({tag, "_busy0"}, {31'd0, busy0}, 32'd0);
    check({tag, "_busy1"}, {31'd0, busy1}, 32'd0);
    check({tag, "_miso0"}, {31'd0, miso0}, 32'd0);
    check({tag, "_rxd0"}, {24'd0, rx_data0}, {24'd0, exp_rx});
    check({tag, "_rxd1"}, {24'd0, rx_data1}, {24'd0, exp_rx});
    check({tag, "_q0_empty"}, exp0_q.size(), 32'd0);
    check({tag, "_q1_empty"}, exp1_q.size(), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    cs      = 1'b1;
    sclk0   = 1'b0;
    mosi    = 1'b0;
    tx_data = 8'h00;
    tx_load = 1'b0;
    wait_clk(3);
    check("rst_tx_ready0", {31'd0, tx_ready0}, 32'd1);
    check("rst_tx_ready1", {31'd0, tx_ready1}, 32'd1);
    check("rst_rx_valid0", {31'd0, rx_valid0}, 32'd0);
    check("rst_abort0", {31'd0, frame_abort0}, 32'd0);
    check_idle("rst", 8'h00);
    reset_n = 1'b1;
    wait_clk(5);

    // Plain byte, empty tx buffer -> miso all zeros
    cs_low();
    check("t1_busy0", {31'd0, busy0}, 32'd1);
    check("t1_busy1", {31'd0, busy1}, 32'd1);
`ifdef SPI_SLAVE_MISO_OE_EN
    check("t1_oe0_active", {31'd0, miso_oe0}, 32'd1);
    check("t1_oe1_active", {31'd0, miso_oe1}, 32'd1);
`endif
    spi_bits(8'hA5, 8, 8'h00, 1'b1);
    cs_high();
    check_idle("t1", 8'hA5);
    check("t1_abort0", abort_cnt0, 32'd0);
    check("t1_abort1", abort_cnt1, 32'd0);
`ifdef SPI_SLAVE_MISO_OE_EN
    check("t1_oe0_idle", {31'd0, miso_oe0}, 32'd0);
    check("t1_oe1_idle", {31'd0, miso_oe1}, 32'd0);
`endif

    // Preloaded transmit byte; second load while full is dropped
    load_tx(8'h3C);
    check("t2_ready_full", {31'd0, tx_ready0}, 32'd0);
    load_tx(8'h99);
    cs_low();
    check("t2_ready_consumed0", {31'd0, tx_ready0}, 32'd1);
    check("t2_ready_consumed1", {31'd0, tx_ready1}, 32'd1);
    spi_bits(8'h00, 8, 8'h3C, 1'b1);
    cs_high();
    check_idle("t2", 8'h00);

    // Back-to-back words with buffer refilled after first consume
    load_tx(8'hC3);
    cs_low();
    load_tx(8'h56);
    check("t3_ready_refill", {31'd0, tx_ready0}, 32'd0);
    spi_bits(8'h12, 8, 8'hC3, 1'b1);
    spi_bits(8'h34, 8, 8'h56, 1'b1);
    cs_high();
    check("t3_ready_end", {31'd0, tx_ready0}, 32'd1);
    check_idle("t3", 8'h34);

    // Aborted partial word, then a full word
    cs_low();
    spi_bits(8'h1F, 5, 8'h00, 1'b0);
    cs_high();
    check("t4_abort0", abort_cnt0, 32'd1);
    check("t4_abort1", abort_cnt1, 32'd1);
    check_idle("t4", 8'h34);
    cs_low();
    spi_bits(8'hFF, 8, 8'h00, 1'b1);
    cs_high();
    check_idle("t4b", 8'hFF);
    check("t4b_abort0", abort_cnt0, 32'd1);

    // Reset mid-byte; rest of that frame must be ignored
    cs_low();
    spi_bits(8'h0F, 3, 8'h00, 1'b0);
    wait_clk(2);
    reset_n = 1'b0;
    #1;
    check("t5_rst_busy0", {31'd0, busy0}, 32'd0);
    check("t5_rst_busy1", {31'd0, busy1}, 32'd0);
    check("t5_rst_ready0", {31'd0, tx_ready0}, 32'd1);
    check("t5_rst_rxd0", {24'd0, rx_data0}, 32'd0);
    check("t5_rst_rxv0", {31'd0, rx_valid0}, 32'd0);
    check("t5_rst_abort0", {31'd0, frame_abort0}, 32'd0);
    wait_clk(2);
    reset_n = 1'b1;
    spi_bits(8'h01, 5, 8'h00, 1'b0);
    check("t5_busy_ignored0", {31'd0, busy0}, 32'd0);
    check("t5_busy_ignored1", {31'd0, busy1}, 32'd0);
    spi_bits(8'hAA, 8, 8'h00, 1'b0);
    cs_high();
    check_idle("t5", 8'h00);
    check("t5_abort0", abort_cnt0, 32'd1);
    cs_low();
    spi_bits(8'h5A, 8, 8'h00, 1'b1);
    cs_high();
    check_idle("t5b", 8'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI responder for the team's SPI initiator, for use on FPGA-side peripherals and in loopback benches.
- Oversamples sclk, cs and mosi on the system clock and deserialises 8-bit words LSB-first into a parallel output with a one-cycle valid strobe.
- Serialises a preloaded transmit byte onto miso in the same frame.
- Supports multiple back-to-back bytes inside one cs-low frame.

Parameters:
- CPOL, 0: idle level of sclk. 0 = idle low, leading edge rising. 1 = idle high, leading edge falling.
- SYNC_STAGES, 2: synchroniser depth for sclk, cs and mosi. Legal range 2..3.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- sclk  in  1  SPI clock from initiator (asynchronous)
- cs  in  1  chip select, active low (asynchronous)
- mosi  in  1  serial data from initiator
- miso  out  1  serial data to initiator
- rx_data  out  8  last completed received byte
- rx_valid  out  1  one-cycle pulse; rx_data updated this cycle
- tx_data  in  8  byte to transmit in the next word slot
- tx_load  in  1  latch tx_data into the transmit buffer
- tx_ready  out  1  transmit buffer empty; tx_load accepted
- busy  out  1  high while a synchronised cs is low
- frame_abort  out  1  one-cycle pulse when cs rises with 1..7 bits of a word received

Behaviour:
- Reset, asynchronous: all outputs 0 except tx_ready = 1. Synchronisers are preset to cs = 1, sclk = CPOL. Shift registers and bit counter are cleared. State = IDLE.
- Synchronisers: sclk, cs and mosi each pass through SYNC_STAGES flops, so mosi stays aligned with sclk.
- Edge detect: compare the synchronised value with a registered previous value.
  - Leading edge: 0->1 when CPOL = 0, 1->0 when CPOL = 1.
  - Trailing edge: the opposite transition.
- Timing requirement: initiator sclk high and low phases must each be at least SYNC_STAGES+1 clk cycles. Behaviour is unspecified below this.
- State machine IDLE:
  - On synchronised cs falling edge: go to ACTIVE, clear bit_cnt, busy = 1.
  - Load tx_shift from the tx buffer if it is full, else load 0x00.
  - Set tx_ready = 1 when the buffer is consumed.
  - miso = tx_shift[0] from the cycle after the cs fall is detected.
- State machine ACTIVE, leading edge:
  - Shift rx_shift right with the synchronised mosi entering bit 7, so the LSB arrives first.
  - bit_cnt increments.
  - On the 8th leading edge (bit_cnt 7 -> 0 wrap):
    - The next cycle, rx_data = completed byte and rx_valid pulses for 1 cycle.
    - Set the word-boundary flag.
- State machine ACTIVE, trailing edge:
  - With the word-boundary flag clear: shift tx_shift right and drive miso = next bit.
  - With the word-boundary flag set: reload tx_shift from the buffer (or 0x00 if empty), miso = new bit 0, clear the flag.
- ACTIVE exit: on synchronised cs rising edge, return to IDLE.
  - bit_cnt != 0: pulse frame_abort, discard partial rx_shift, leave rx_data unchanged, no rx_valid.
  - bit_cnt == 0: no abort.
  - busy = 0, miso = 0.
  - A trailing edge coincident with or after the cs rise is ignored.
- Transmit buffer:
  - tx_load with tx_ready = 1 latches tx_data and sets tx_ready = 0 on the next cycle.
  - tx_load with tx_ready = 0 is ignored; the buffer is not overwritten.
  - tx_load in the same cycle as a buffer consume is accepted: the consume takes the old contents and the new byte is latched, tx_ready stays 0.
- rx_valid and frame_abort are never asserted in the same cycle.
- Reset asserted mid-frame: immediate return to reset values. A frame still in progress after reset release is ignored until cs is seen high, then low again.

Optional Feature:
- Macro SPI_SLAVE_MISO_OE_EN.
- Defined: adds output port miso_oe (1 bit).
  - miso_oe = 1 only while state = ACTIVE, else 0.
  - Used to drive a shared, tri-stated miso line.
  - Reset value 0.
- Undefined: no miso_oe port. miso is driven always and held 0 outside ACTIVE.

Test Plan:
- CPOL = 0; initiator sends 0xA5 with 20 clk/bit, cs framed -> exactly one rx_valid, rx_data = 0xA5, no frame_abort, busy low after cs rise.
- Preload tx_data = 0x3C via tx_load before cs falls; initiator sends 0x00 -> miso bits sampled on leading edges read 0,0,1,1,1,1,0,0 (0x3C LSB-first); tx_ready returns to 1 at cs fall.
- Back-to-back 0x12, 0x34 in one cs-low frame; tx buffer reloaded with 0x56 after the first consume -> rx_valid twice (0x12 then 0x34); second miso word = 0x56.
- cs raised after 5 leading edges -> frame_abort pulses once, no rx_valid, rx_data keeps previous value; next full byte 0xFF is received correctly.
- CPOL = 1 with the same 0xA5 stimulus -> identical rx_data; reset_n pulsed low mid-byte -> all outputs at reset values within 0 clk (async); the remaining bits of that frame produce no rx_valid.
- SPI_SLAVE_MISO_OE_EN defined -> miso_oe = 0 in idle and 1 only between synchronised cs fall and rise.
